dis_pal_timing: RTL and testbench



---
 rtl/dis_pal_timing_if.sv | 21 ++
 rtl/dis_pal_timing.sv | 191 +++++++++++++++++++
 tb/tb_dis_pal_timing.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dis_pal_timing_if.sv
// Pixel stream between the upstream source and the PAL raster sequencer.
// The source drives data/valid; the sequencer answers with ready.
interface dis_pal_timing_if #(
  parameter int unsigned DATA_WIDTH = 10
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/dis_pal_timing.sv
// PAL raster sequencer: walks a non-interlaced 312-line field, produces the
// sync/blank/pixel stream for the DAC level converter and pulls active pixels
// from an upstream valid/ready source, substituting black when it is late.
module dis_pal_timing #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned H_TOTAL     = 864,
  parameter int unsigned H_SYNC      = 64,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACTIVE    = 720,
  parameter int unsigned V_TOTAL     = 312,
  parameter int unsigned V_BROAD     = 3,
  parameter int unsigned V_EQ        = 3,
  parameter int unsigned V_ACT_START = 23,
  parameter int unsigned V_ACTIVE    = 280
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  dis_pal_timing_if.slave       din,
  output logic                  dout_sync_n,
  output logic                  dout_blank_n,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sof,
  output logic                  underflow,
  input  logic                  underflow_clr
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam int unsigned H_HALF = H_TOTAL / 2;

  // Raster boundaries pre-sized to the counter width.
  localparam cnt_t C_H_LAST      = cnt_t'(H_TOTAL - 1);
  localparam cnt_t C_V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam cnt_t C_H_SYNC      = cnt_t'(H_SYNC);
  localparam cnt_t C_EQ_W        = cnt_t'(H_SYNC / 2);
  localparam cnt_t C_H_HALF      = cnt_t'(H_HALF);
  localparam cnt_t C_EQ_END1     = cnt_t'(H_HALF + H_SYNC / 2);
  localparam cnt_t C_BROAD_END0  = cnt_t'(H_HALF - H_SYNC);
  localparam cnt_t C_BROAD_END1  = cnt_t'(H_TOTAL - H_SYNC);
  localparam cnt_t C_V_BROAD     = cnt_t'(V_BROAD);
  localparam cnt_t C_V_EQ_END    = cnt_t'(V_BROAD + V_EQ);
  localparam cnt_t C_V_EQ_TAIL   = cnt_t'(V_TOTAL - V_EQ);
  localparam cnt_t C_V_ACT0      = cnt_t'(V_ACT_START);
  localparam cnt_t C_V_ACT1      = cnt_t'(V_ACT_START + V_ACTIVE);
  localparam cnt_t C_H_ACT0      = cnt_t'(H_ACT_START);
  localparam cnt_t C_H_ACT1      = cnt_t'(H_ACT_START + H_ACTIVE);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    LT_NORMAL,
    LT_EQ,
    LT_BROAD
  } line_t;

  state_t r_state;
  state_t w_state_nxt;
  cnt_t   r_h_cnt;
  cnt_t   r_v_cnt;
  logic   w_run;
  logic   w_h_last;
  logic   w_v_last;
  line_t  w_line;
  logic   w_sync_n;
  logic   w_active;

  assign w_h_last = (r_h_cnt == C_H_LAST);
  assign w_v_last = (r_v_cnt == C_V_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: start on en, stop only after the last clock of a field.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_h_last && w_v_last && !en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Horizontal/vertical raster counters; held at zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_run) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + cnt_t'(1);
      end else begin
        r_h_cnt <= r_h_cnt + cnt_t'(1);
      end
    end else begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  // Line type from the vertical position.
  always_comb begin
    w_line = LT_NORMAL;
    if (r_v_cnt < C_V_BROAD) begin
      w_line = LT_BROAD;
    end else if ((r_v_cnt < C_V_EQ_END) || (r_v_cnt >= C_V_EQ_TAIL)) begin
      w_line = LT_EQ;
    end
  end

  // Sync pulse shape for the current line type.
  always_comb begin
    w_sync_n = 1'b1;
    case (w_line)
      LT_NORMAL: begin
        if (r_h_cnt < C_H_SYNC) begin
          w_sync_n = 1'b0;
        end
      end
      LT_EQ: begin
        if ((r_h_cnt < C_EQ_W) ||
            ((r_h_cnt >= C_H_HALF) && (r_h_cnt < C_EQ_END1))) begin
          w_sync_n = 1'b0;
        end
      end
      LT_BROAD: begin
        if ((r_h_cnt < C_BROAD_END0) ||
            ((r_h_cnt >= C_H_HALF) && (r_h_cnt < C_BROAD_END1))) begin
          w_sync_n = 1'b0;
        end
      end
      default: w_sync_n = 1'b1;
    endcase
  end

  // Active picture window; the source is asked for a pixel on every active
  // clock regardless of whether it has one.
  assign w_active = w_run &&
                    (r_v_cnt >= C_V_ACT0) && (r_v_cnt < C_V_ACT1) &&
                    (r_h_cnt >= C_H_ACT0) && (r_h_cnt < C_H_ACT1);

  assign din.ready = w_active;

  // Output registers: sync, blank and data leave mutually aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_sync_n  <= 1'b1;
      dout_blank_n <= 1'b0;
      dout_data    <= '0;
      dout_sof     <= 1'b0;
    end else begin
      dout_sync_n  <= w_run ? w_sync_n : 1'b1;
      dout_blank_n <= w_active;
      dout_data    <= (w_active && din.valid) ? din.data : '0;
      dout_sof     <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  // Sticky underflow flag; a new miss outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (w_active && !din.valid) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dis_pal_timing.sv
// Bench for dis_pal_timing: a scaled-down raster checked every cycle against a
// field-position model, literal pulse/pixel checks on one captured field, and
// a default-parameter instance pinned on its first broad line.
module tb_dis_pal_timing;
  localparam int DW    = 10;
  localparam int HT    = 64;
  localparam int HS    = 8;
  localparam int HAS   = 12;
  localparam int HA    = 48;
  localparam int VT    = 40;
  localparam int VB    = 3;
  localparam int VE    = 3;
  localparam int VAS   = 8;
  localparam int VA    = 24;
  localparam int HH    = HT / 2;
  localparam int FIELD = HT * VT;
  localparam int DEF_HT = 864;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, underflow_clr;
  logic          dout_sync_n, dout_blank_n, dout_sof, underflow;
  logic [DW-1:0] dout_data;

  dis_pal_timing_if #(.DATA_WIDTH(DW)) din_if ();

  dis_pal_timing #(
    .DATA_WIDTH(DW), .CNT_WIDTH(10), .H_TOTAL(HT), .H_SYNC(HS),
    .H_ACT_START(HAS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_BROAD(VB),
    .V_EQ(VE), .V_ACT_START(VAS), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din_if),
    .dout_sync_n(dout_sync_n), .dout_blank_n(dout_blank_n),
    .dout_data(dout_data), .dout_sof(dout_sof),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  // Default-parameter instance sharing clk/rst/en.
  logic       d_sync_n, d_blank_n, d_sof, d_uf, d_clr;
  logic [9:0] d_data;
  dis_pal_timing_if #(.DATA_WIDTH(10)) def_if ();

  dis_pal_timing dut_def (
    .clk(clk), .rst(rst), .en(en), .din(def_if),
    .dout_sync_n(d_sync_n), .dout_blank_n(d_blank_n),
    .dout_data(d_data), .dout_sof(d_sof),
    .underflow(d_uf), .underflow_clr(d_clr)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit f_sync_low(input int h, input int v);
    int idx, off, w;
    idx = (h >= HH) ? 1 : 0;
    off = h - idx * HH;
    if (v < VB)                         w = HH - HS;
    else if (v < VB + VE || v >= VT - VE) w = HS / 2;
    else                                w = (idx == 0) ? HS : 0;
    return off < w;
  endfunction

  function automatic bit f_active(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (v >= VAS) && (v < VAS + VA) && (h >= HAS) && (h < HAS + HA);
  endfunction

  bit            m_run;
  int            m_pos;
  bit            chk_en = 1'b0;
  logic          e_sync, e_blank, e_sof, e_uf, e_ready;
  logic [DW-1:0] e_data;

  initial begin
    bit act;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_run = 1'b0; m_pos = 0;
        e_sync = 1'b1; e_blank = 1'b0; e_data = '0; e_sof = 1'b0; e_uf = 1'b0;
      end else begin
        act     = m_run && f_active(m_pos);
        e_sync  = m_run ? !f_sync_low(m_pos % HT, m_pos / HT) : 1'b1;
        e_blank = act;
        e_data  = (act && din_if.valid) ? din_if.data : '0;
        e_sof   = m_run && (m_pos == 0);
        if (act && !din_if.valid) e_uf = 1'b1;
        else if (underflow_clr)   e_uf = 1'b0;
        if (!m_run) begin
          if (en) begin m_run = 1'b1; m_pos = 0; end
        end else if (m_pos == FIELD - 1 && !en) begin
          m_run = 1'b0; m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % FIELD;
        end
      end
      e_ready = m_run && f_active(m_pos);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("sync_n",    dout_sync_n,  e_sync);
        chk("blank_n",   dout_blank_n, e_blank);
        chk("data",      dout_data,    e_data);
        chk("sof",       dout_sof,     e_sof);
        chk("underflow", underflow,    e_uf);
        chk("din_ready", din_if.ready, e_ready);
      end
    end
  end

  // ---------------- literal helpers ----------------
  bit            s_sync [FIELD];
  bit            s_blank[FIELD];
  bit            s_rdy  [FIELD];
  logic [DW-1:0] s_data [FIELD];
  bit            d_sync [DEF_HT];

  task automatic runs(input bit q[$], output int n, output int l0, output int s0,
                      output int l1, output int s1);
    n = 0; l0 = 0; s0 = -1; l1 = 0; s1 = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i]) begin
        if (i == 0 || q[i-1]) begin
          n++;
          if (n == 1) s0 = i; else if (n == 2) s1 = i;
        end
        if (n == 1) l0++; else if (n == 2) l1++;
      end
    end
  endtask

  task automatic check_runs(input string tag, input bit q[$], input int n_exp,
                            input int len_exp, input int gap_exp);
    int n, l0, s0, l1, s1;
    runs(q, n, l0, s0, l1, s1);
    chk({tag, "_runs"}, n, n_exp);
    chk({tag, "_len0"}, l0, len_exp);
    chk({tag, "_start0"}, s0, 0);
    if (n_exp == 2) begin
      chk({tag, "_len1"}, l1, len_exp);
      chk({tag, "_gap"}, s1 - s0, gap_exp);
    end
  endtask

  task automatic check_line(input int line, input int n_exp, input int len_exp, input int gap_exp);
    bit q[$];
    for (int h = 0; h < HT; h++) q.push_back(s_sync[line * HT + h]);
    check_runs($sformatf("line%0d", line), q, n_exp, len_exp, gap_exp);
  endtask

  task automatic wait_sof(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (dout_sof === 1'b1) ok = 1'b1;
    end
    chk("sof_seen", ok, 1'b1);
  endtask

  task automatic wait_ready(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (din_if.ready === 1'b1) ok = 1'b1;
    end
    chk("ready_seen", ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int accepted, bl_out, bl_tot, rdy_bad, dat_bad, n10, f10;
    bit dq[$];
    rst = 1'b1; en = 1'b1; underflow_clr = 1'b0; d_clr = 1'b0;
    din_if.valid = 1'b1; din_if.data = '0;
    def_if.valid = 1'b1; def_if.data = '0;

    // Reset with en held high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_sync_n", dout_sync_n, 1'b1);
      chk("rst_blank_n", dout_blank_n, 1'b0);
      chk("rst_data", dout_data, '0);
      chk("rst_uf", underflow, 1'b0);
      chk("rst_ready", din_if.ready, 1'b0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Capture one field with an incrementing pixel source.
    wait_sof(10);
    chk("def_sof", d_sof, 1'b1);
    chk("sof_broad_sync", dout_sync_n, 1'b0);
    accepted = 0;
    for (int i = 0; i < FIELD; i++) begin
      bit r;
      if (i > 0) @(negedge clk);
      s_sync[i] = dout_sync_n; s_blank[i] = dout_blank_n;
      s_data[i] = dout_data;   s_rdy[i]   = din_if.ready;
      if (i < DEF_HT) d_sync[i] = d_sync_n;
      r = din_if.ready;
      @(posedge clk); #1;
      if (r) begin din_if.data = din_if.data + 1'b1; accepted++; end
    end

    for (int l = 0; l < VB; l++) check_line(l, 2, HH - HS, HH);
    for (int l = VB; l < VB + VE; l++) check_line(l, 2, HS / 2, HH);
    for (int l = VT - VE; l < VT; l++) check_line(l, 2, HS / 2, HH);
    check_line(10, 1, HS, 0);

    bl_out = 0; bl_tot = 0; rdy_bad = 0; dat_bad = 0; n10 = 0; f10 = -1;
    for (int i = 0; i < FIELD; i++) begin
      int v, h;
      v = i / HT; h = i % HT;
      if (s_blank[i]) begin
        bl_tot++;
        if (v < VAS || v >= VAS + VA) bl_out++;
        if (v == 10) begin n10++; if (f10 < 0) f10 = h; end
      end
      if (i > 0 && s_rdy[i-1] != s_blank[i]) rdy_bad++;
    end
    for (int k = 0; k < HA; k++) begin
      logic [DW-1:0] want;
      want = DW'(k);
      if (s_data[VAS * HT + HAS + k] !== want || !s_blank[VAS * HT + HAS + k]) dat_bad++;
    end
    chk("line10_blank_len", n10, HA);
    chk("line10_blank_start", f10, HAS);
    chk("blank_outside", bl_out, 0);
    chk("blank_total", bl_tot, VA * HA);
    chk("pixels_accepted", accepted, VA * HA);
    chk("ready_leads_blank", rdy_bad, 0);
    chk("first_line_pixels", dat_bad, 0);
    for (int h = 0; h < DEF_HT; h++) dq.push_back(d_sync[h]);
    check_runs("def_line0", dq, 2, 368, 432);

    // Underflow: miss one pixel, clear, then clear colliding with a miss.
    wait_ready(2 * FIELD);
    din_if.valid = 1'b0;
    @(posedge clk); #1 din_if.valid = 1'b1;
    @(negedge clk);
    chk("uf_blank", dout_blank_n, 1'b1);
    chk("uf_data", dout_data, '0);
    chk("uf_set", underflow, 1'b1);
    underflow_clr = 1'b1;
    @(posedge clk); #1 underflow_clr = 1'b0;
    @(negedge clk);
    chk("uf_clear", underflow, 1'b0);
    wait_ready(2 * FIELD);
    underflow_clr = 1'b1; din_if.valid = 1'b0;
    @(posedge clk); #1 underflow_clr = 1'b0; din_if.valid = 1'b1;
    @(negedge clk);
    chk("uf_set_wins", underflow, 1'b1);
    underflow_clr = 1'b1;
    @(posedge clk); #1 underflow_clr = 1'b0;

    // Stop mid-field, then restart.
    wait_sof(FIELD + 10);
    repeat (20 * HT) @(negedge clk);
    en = 1'b0;
    repeat (FIELD - HT - 20 * HT) @(negedge clk);
    chk("stop_still_running", dout_sync_n, 1'b0);
    repeat (HT) @(negedge clk);
    chk("stop_idle_sync", dout_sync_n, 1'b1);
    chk("stop_idle_blank", dout_blank_n, 1'b0);
    chk("stop_no_sof", dout_sof, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_ready", din_if.ready, 1'b0);
    chk("idle_sync", dout_sync_n, 1'b1);
    en = 1'b1;
    @(negedge clk);
    chk("restart_sof_early", dout_sof, 1'b0);
    @(negedge clk);
    chk("restart_sof", dout_sof, 1'b1);

    // Randomized run against the model.
    for (int i = 0; i < 3 * FIELD; i++) begin
      @(negedge clk);
      din_if.valid  = ($urandom_range(0, 7) != 0);
      din_if.data   = DW'($urandom);
      underflow_clr = ($urandom_range(0, 15) == 0);
      en            = ($urandom_range(0, 19) != 0);
      rst           = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; underflow_clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
